// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller.
// Hits are answered combinationally; misses run a word-serial writeback and refill over req/ack.
//   state | meaning
//   IDLE  | serving hits, detecting misses
//   WB    | writing the dirty victim line back, one word per ack
//   FILL  | refilling the line for the held request, one word per ack
module dcache_ctrl #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);
    localparam int TAG_ADDR_LEN = 32 - 2 - LINE_ADDR_LEN - SET_ADDR_LEN;
    localparam int LINE_SIZE    = 1 << LINE_ADDR_LEN;
    localparam int SET_SIZE     = 1 << SET_ADDR_LEN;

    typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

    state_t state, state_nxt;

    logic [31:0]              data_mem [SET_SIZE][LINE_SIZE];
    logic [TAG_ADDR_LEN-1:0]  tag_mem  [SET_SIZE];
    logic [SET_SIZE-1:0]      valid;
    logic [SET_SIZE-1:0]      dirty;

    logic [LINE_ADDR_LEN-1:0] cnt;
    logic [TAG_ADDR_LEN-1:0]  miss_tag;
    logic [SET_ADDR_LEN-1:0]  miss_set;
    logic                     retry;

    logic [TAG_ADDR_LEN-1:0]  req_tag;
    logic [SET_ADDR_LEN-1:0]  req_set;
    logic [LINE_ADDR_LEN-1:0] req_word;
    logic                     req;
    logic                     hit;
    logic                     last_word;
    logic                     unused_addr_bits;

    assign req_tag          = addr[31 -: TAG_ADDR_LEN];
    assign req_set          = addr[2 + LINE_ADDR_LEN +: SET_ADDR_LEN];
    assign req_word         = addr[2 +: LINE_ADDR_LEN];
    assign unused_addr_bits = ^addr[1:0];

    assign req       = rd_req | wr_req;
    assign hit       = req && valid[req_set] && (tag_mem[req_set] == req_tag);
    assign last_word = &cnt;

    always_comb begin
        state_nxt = state;
        miss      = 1'b0;
        rd_data   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                miss = req && !hit;
                if (hit) begin
                    rd_data = data_mem[req_set][req_word];
                end
                if (req && !hit) begin
                    state_nxt = (valid[req_set] && dirty[req_set]) ? WB : FILL;
                end
            end
            WB: begin
                miss      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {tag_mem[miss_set], miss_set, cnt, 2'b00};
                mem_wdata = data_mem[miss_set][cnt];
                if (mem_ack && last_word) begin
                    state_nxt = FILL;
                end
            end
            FILL: begin
                miss     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {miss_tag, miss_set, cnt, 2'b00};
                if (mem_ack && last_word) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Requester may still be holding its request while reset is asserted.
        if (!rst_n) begin
            miss = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            miss_tag <= '0;
            miss_set <= '0;
            retry    <= 1'b0;
            valid    <= '0;
            dirty    <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            state <= state_nxt;
            retry <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        if (wr_req) begin
                            dirty[req_set] <= 1'b1;
                        end
                        if (!retry) begin
                            hit_cnt <= hit_cnt + 32'd1;
                        end
                    end else if (req) begin
                        miss_tag <= req_tag;
                        miss_set <= req_set;
                        miss_cnt <= miss_cnt + 32'd1;
                        cnt      <= '0;
                    end
                end
                WB: begin
                    if (mem_ack) begin
                        cnt <= last_word ? '0 : cnt + 1'b1;
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        cnt <= last_word ? '0 : cnt + 1'b1;
                        if (last_word) begin
                            valid[miss_set] <= 1'b1;
                            dirty[miss_set] <= 1'b0;
                            retry           <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Data and tag arrays carry no reset; valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (state == IDLE && hit && wr_req) begin
            data_mem[req_set][req_word] <= wr_data;
        end else if (state == FILL && mem_ack) begin
            data_mem[miss_set][cnt] <= mem_rdata;
        end
        if (state == FILL && mem_ack && last_word) begin
            tag_mem[miss_set] <= miss_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: expected memory transactions and load data are queued
// by the stimulus and consumed by independent memory-responder and load monitors.
module tb_dcache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_req = 1'b0, wr_req = 1'b0;
    logic [31:0] addr = '0, wr_data = '0;
    logic [31:0] rd_data;
    logic        miss, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] hit_cnt, miss_cnt;

    dcache_ctrl dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .miss(miss), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_txn_t;

    mem_txn_t    exp_mem[$];
    logic [31:0] exp_rd[$];
    logic [31:0] mem_model [int unsigned];
    int          errors = 0;
    int          checks = 0;
    int          ack_delay = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // Memory responder: acks each word after ack_delay extra cycles, checks against the queue.
    logic        new_word = 1'b1;
    int          waitc = 0;
    logic [31:0] cap_addr, cap_wdata;
    mem_txn_t    t;

    always @(negedge clk) begin
        if (mem_ack) begin
            mem_ack  = 1'b0;
            new_word = 1'b1;
        end
        if (!rst_n || !mem_req) begin
            new_word = 1'b1;
        end else begin
            if (new_word) begin
                new_word  = 1'b0;
                waitc     = 0;
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
            end else begin
                waitc++;
            end
            check("miss_during_mem", {31'd0, miss}, 32'd1);
            if (waitc >= ack_delay) begin
                if (waitc > 0) begin
                    check("mem_addr_stable", mem_addr, cap_addr);
                    if (mem_we) check("mem_wdata_stable", mem_wdata, cap_wdata);
                end
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mem_unexpected: addr %h we %0d", mem_addr, mem_we);
                end else begin
                    t = exp_mem.pop_front();
                    check("mem_we", {31'd0, mem_we}, {31'd0, t.we});
                    check("mem_addr", mem_addr, t.addr);
                    if (t.we) check("mem_wdata", mem_wdata, t.wdata);
                end
                if (mem_we) mem_model[mem_addr] = mem_wdata;
                else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : mem_addr;
                mem_ack = 1'b1;
            end
        end
    end

    // Load monitor: every accepted load is compared with the next expected value.
    always @(negedge clk) begin
        if (rst_n && rd_req && !wr_req && !miss) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %h", rd_data);
            end else begin
                check("rd_data", rd_data, exp_rd.pop_front());
            end
        end
    end

    task automatic push_line(input logic we, input logic [31:0] base, input int dw,
                             input logic [31:0] dv);
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            a = base + 32'(4 * i);
            exp_mem.push_back('{we: we, addr: a, wdata: (i == dw) ? dv : a});
        end
    endtask

    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic exp_miss);
        int n;
        @(posedge clk); #1;
        rd_req = !wr; wr_req = wr; addr = a; wr_data = d;
        @(negedge clk);
        check("miss_first_cycle", {31'd0, miss}, {31'd0, exp_miss});
        if (!exp_miss) check("no_mem_req", {31'd0, mem_req}, 32'd0);
        n = 0;
        while (miss && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (miss) fail_now("miss_timeout");
        @(posedge clk); #1;
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    initial begin
        int n;
        #1;
        check("rst_miss", {31'd0, miss}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // cold miss, clean refill
        push_line(1'b0, 32'h40, -1, 32'h0);
        exp_rd.push_back(32'h40);
        issue(1'b0, 32'h40, 32'h0, 1'b1);
        check("t1_miss_cnt", miss_cnt, 32'd1);
        check("t1_hit_cnt", hit_cnt, 32'd0);

        exp_rd.push_back(32'h44);
        issue(1'b0, 32'h44, 32'h0, 1'b0);
        check("t2_hit_cnt", hit_cnt, 32'd1);

        issue(1'b1, 32'h48, 32'hDEADBEEF, 1'b0);
        exp_rd.push_back(32'hDEADBEEF);
        issue(1'b0, 32'h48, 32'h0, 1'b0);
        check("t3_hit_cnt", hit_cnt, 32'd3);

        // conflict miss on a dirty line: writeback then refill
        push_line(1'b1, 32'h40, 2, 32'hDEADBEEF);
        push_line(1'b0, 32'h140, -1, 32'h0);
        exp_rd.push_back(32'h140);
        issue(1'b0, 32'h140, 32'h0, 1'b1);
        check("t4_miss_cnt", miss_cnt, 32'd2);
        check("t4_hit_cnt_retry", hit_cnt, 32'd3);

        // slow memory: dirty writeback and refill with 5 wait cycles per word
        issue(1'b1, 32'h140, 32'h12345678, 1'b0);
        check("t5_hit_cnt_wr", hit_cnt, 32'd4);
        ack_delay = 5;
        push_line(1'b1, 32'h140, 0, 32'h12345678);
        push_line(1'b0, 32'h40, -1, 32'h0);
        exp_rd.push_back(32'hDEADBEEF);
        issue(1'b0, 32'h48, 32'h0, 1'b1);
        check("t5_miss_cnt", miss_cnt, 32'd3);
        check("t5_hit_cnt", hit_cnt, 32'd4);

        // reset during refill word 3
        ack_delay = 2;
        for (int i = 0; i < 3; i++) begin
            exp_mem.push_back('{we: 1'b0, addr: 32'h140 + 32'(4 * i), wdata: 32'h0});
        end
        @(posedge clk); #1;
        rd_req = 1'b1; addr = 32'h140;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_addr == 32'h14C) && n < 500);
        if (n >= 500) fail_now("t6_word3_timeout");
        #1 rst_n = 1'b0;
        #1;
        check("t6_mem_req", {31'd0, mem_req}, 32'd0);
        check("t6_miss", {31'd0, miss}, 32'd0);
        check("t6_miss_cnt", miss_cnt, 32'd0);
        check("t6_hit_cnt", hit_cnt, 32'd0);
        check("t6_pending_words", exp_mem.size(), 32'd0);
        rd_req = 1'b0;
        exp_mem.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        ack_delay = 0;
        push_line(1'b0, 32'h140, -1, 32'h0);
        exp_rd.push_back(32'h12345678);
        issue(1'b0, 32'h140, 32'h0, 1'b1);
        check("t6_miss_cnt_after", miss_cnt, 32'd1);
        check("t6_hit_cnt_after", hit_cnt, 32'd0);

        repeat (3) @(posedge clk);
        check("left_mem_txns", exp_mem.size(), 32'd0);
        check("left_rd", exp_rd.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
